// File: rtl/flopoco_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flopoco_pkg
// Purpose  : Shared widths, exception encoding and packed word layouts for
//            the IEEE -> FloPoCo 5/5 input formatter.
// Revision : 1.0  initial release
// ============================================================================
package flopoco_pkg;

  localparam int WE   = 5;
  localparam int WF   = 5;
  localparam int BIAS = 15;

  // FloPoCo exception field
  typedef enum logic [1:0] {
    EXN_ZERO = 2'b00,
    EXN_NORM = 2'b01,
    EXN_INF  = 2'b10,
    EXN_NAN  = 2'b11
  } exn_t;

  typedef struct packed {
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } ieee_t;

  typedef struct packed {
    exn_t          exn;
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
  } flopoco_t;

  // First-stage decode: class, raw fields and leading-one information.
  // norm_shift marks a subnormal whose leading one sits in the fraction MSB.
  typedef struct packed {
    exn_t          exn;
    logic          sign;
    logic [WE-1:0] exp;
    logic [WF-1:0] frac;
    logic          norm_shift;
    logic          flush;
  } dec_t;

  // Second-stage payload: packed output word plus its flush marker
  typedef struct packed {
    flopoco_t word;
    logic     flush;
  } pack_t;

  localparam int DEC_W  = $bits(dec_t);
  localparam int PACK_W = $bits(pack_t);

endpackage
`default_nettype wire

// File: rtl/fp_ieee_to_flopoco_5_5_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : fp_pipe_stage
// Purpose  : Generic valid/ready register slice. Loads when empty or when
//            its current word leaves in the same cycle (bubble collapsing).
// Revision : 1.0  initial release
// ============================================================================
module fp_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;
  logic         load;

  assign in_ready  = !valid_q || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Next-state: take a new word, drain the current one, or hold while stalled
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Stage register; reset discards any in-flight word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_ieee_to_flopoco_5_5.sv
`default_nettype none
// ============================================================================
// Module   : fp_ieee_to_flopoco_5_5
// Purpose  : Converts packed IEEE-style {sign, exp, frac} into FloPoCo
//            {exn, sign, exp, frac} through a 2-stage valid/ready pipeline,
//            with sticky {flush, inf, nan} flags.
//            Define FP_IEEE2FLOPOCO_SUBNORM_EN to normalise subnormals whose
//            fraction MSB is set instead of flushing every subnormal.
// Revision : 1.0  initial release
// ============================================================================
module fp_ieee_to_flopoco_5_5 #(
  parameter int ID = 1,
  parameter int WE = 5,
  parameter int WF = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WE+WF:0]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WE+WF+2:0]   out_data,
  input  logic               flag_clr,
  output logic [2:0]         flags
);

  import flopoco_pkg::*;

  // Only the 5/5 geometry with the matching bias is supported
  if (WE != 5 || WF != 5 || BIAS != 15 || ID < 0) begin : g_cfg_check
    $error("fp_ieee_to_flopoco_5_5: unsupported configuration");
  end

  ieee_t    in_word;
  dec_t     dec;
  dec_t     s1_q;
  logic     s1_v, s2_rdy;
  pack_t    pk;
  pack_t    s2_q;
  logic     fire;
  logic [2:0] flags_d, flags_q;

  assign in_word = ieee_t'(in_data);

  // Classify the incoming IEEE word and gather leading-one information
  always_comb begin
    dec            = '0;
    dec.sign       = in_word.sign;
    dec.exp        = in_word.exp;
    dec.frac       = in_word.frac;
    if (&in_word.exp) begin
      dec.exn = (|in_word.frac) ? EXN_NAN : EXN_INF;
    end else if (in_word.exp == '0) begin
      if (in_word.frac == '0) begin
        dec.exn = EXN_ZERO;
      end else begin
`ifdef FP_IEEE2FLOPOCO_SUBNORM_EN
        // Only a leading one in the fraction MSB lands inside FloPoCo range
        if (in_word.frac[WF-1]) begin
          dec.exn        = EXN_NORM;
          dec.norm_shift = 1'b1;
        end else begin
          dec.exn   = EXN_ZERO;
          dec.flush = 1'b1;
        end
`else
        dec.exn   = EXN_ZERO;
        dec.flush = 1'b1;
`endif
      end
    end else begin
      dec.exn = EXN_NORM;
    end
  end

  fp_pipe_stage #(.W(DEC_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec),
    .out_valid (s1_v),
    .out_ready (s2_rdy),
    .out_data  (s1_q)
  );

  // Pack the FloPoCo word; specials carry zero exponent/fraction.
  // Bias is identical in both formats so normal fields pass unchanged.
  always_comb begin
    pk           = '0;
    pk.word.exn  = s1_q.exn;
    pk.word.sign = s1_q.sign;
    pk.flush     = s1_q.flush;
    if (s1_q.exn == EXN_NORM) begin
      if (s1_q.norm_shift) begin
        pk.word.exp  = '0;
        pk.word.frac = {s1_q.frac[WF-2:0], 1'b0};
      end else begin
        pk.word.exp  = s1_q.exp;
        pk.word.frac = s1_q.frac;
      end
    end
  end

  fp_pipe_stage #(.W(PACK_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_v),
    .in_ready  (s2_rdy),
    .in_data   (pk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_data = s2_q.word;
  assign fire     = out_valid && out_ready;

  // Sticky flags: set on output transfer, cleared on request, set wins
  always_comb begin
    flags_d = flag_clr ? 3'b000 : flags_q;
    if (fire) begin
      flags_d = flags_d | {s2_q.flush,
                           s2_q.word.exn == EXN_INF,
                           s2_q.word.exn == EXN_NAN};
    end
  end

  // Flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_ieee_to_flopoco_5_5.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_ieee_to_flopoco_5_5
// Purpose  : Scoreboard bench for the IEEE -> FloPoCo 5/5 formatter.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_ieee_to_flopoco_5_5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [12:0] out_data;
  logic        flag_clr = 1'b0;
  logic [2:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [12:0] sb[$];

  fp_ieee_to_flopoco_5_5 #(.ID(1), .WE(5), .WF(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flag_clr  (flag_clr),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Present one word and push its expected result when it is accepted
  task automatic send(input logic [10:0] w, input logic [12:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        fail_now("send_accept");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for every expected word to emerge, then let the flags settle
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("flags_cleared", flags, 3'b000);
  endtask

  // Monitor: pop and compare on every transfer; while stalled the held word
  // must be the one at the head of the scoreboard
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %0h expected none", out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e);
          end
        end else if (sb.size() != 0) begin
          chk("hold_data", out_data, sb[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [12:0] SUB_A_EXP =
`ifdef FP_IEEE2FLOPOCO_SUBNORM_EN
    13'b01_0_00000_01000;
`else
    13'b00_0_00000_00000;
`endif
  localparam logic [12:0] SUB_B_EXP =
`ifdef FP_IEEE2FLOPOCO_SUBNORM_EN
    13'b01_1_00000_11110;
`else
    13'b00_1_00000_00000;
`endif
  localparam logic [2:0] SUB_FLAGS =
`ifdef FP_IEEE2FLOPOCO_SUBNORM_EN
    3'b000;
`else
    3'b100;
`endif

  initial begin
    logic [10:0] vin [4];
    logic [12:0] vexp[4];

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, 0);
    chk("rst_flags",     flags, 0);
    chk("rst_in_ready",  in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 1.0 passthrough with latency check
    send(11'b0_01111_00000, 13'b01_0_01111_00000);
    chk("lat_s1_only", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_two_cycles", out_valid, 1);
    drain("drain_one");
    chk("flags_normal", flags, 3'b000);

    // Assorted normals at the exponent boundaries plus a negative NaN
    vin[0] = 11'b1_11110_11111; vexp[0] = 13'b01_1_11110_11111;
    vin[1] = 11'b0_00001_00000; vexp[1] = 13'b01_0_00001_00000;
    vin[2] = 11'b1_11111_10000; vexp[2] = 13'b11_1_00000_00000;
    vin[3] = 11'b0_10101_01010; vexp[3] = 13'b01_0_10101_01010;
    for (int i = 0; i < 4; i++) send(vin[i], vexp[i]);
    drain("drain_table");
    chk("flags_table", flags, 3'b001);
    clear_flags();

    // Specials back-to-back
    send(11'b0_11111_00001, 13'b11_0_00000_00000);
    send(11'b0_11111_00000, 13'b10_0_00000_00000);
    send(11'b1_00000_00000, 13'b00_1_00000_00000);
    drain("drain_specials");
    chk("flags_specials", flags, 3'b011);
    clear_flags();

    // Subnormals with the leading one in the fraction MSB
    send(11'b0_00000_10100, SUB_A_EXP);
    send(11'b1_00000_11111, SUB_B_EXP);
    drain("drain_sub_a");
    chk("flags_sub_a", flags, SUB_FLAGS);
    clear_flags();

    // Deep subnormal always flushes
    send(11'b0_00000_00011, 13'b00_0_00000_00000);
    drain("drain_sub_b");
    chk("flags_sub_b", flags, 3'b100);
    clear_flags();

    // Backpressure: two words fill the pipe, the third waits
    out_ready = 1'b0;
    send(11'b0_10000_00001, 13'b01_0_10000_00001);
    send(11'b0_10001_00010, 13'b01_0_10001_00010);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 11'b0_10010_00011;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(11'b0_10010_00011, 13'b01_0_10010_00011);
    drain("drain_bp");

    // Reset with both stages full
    send(11'b0_11111_11111, 13'b11_0_00000_00000);
    drain("drain_pre_rst");
    chk("flags_pre_rst", flags, 3'b001);
    out_ready = 1'b0;
    send(11'b0_10011_00100, 13'b01_0_10011_00100);
    send(11'b0_10100_00101, 13'b01_0_10100_00101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_flags", flags, 0);
    chk("arst_in_ready", in_ready, 1);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", out_valid, 0);

    // Clear coinciding with a NaN transfer: set wins
    send(11'b0_11111_00100, 13'b11_0_00000_00000);
    @(posedge clk);
    #1;
    chk("clr_nan_valid", out_valid, 1);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("clr_vs_set", flags, 3'b001);
    chk("sb_empty_end", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_ieee_to_flopoco_5_5.md
Name: fp_ieee_to_flopoco_5_5

Overview:
- Input formatter placed directly upstream of the 13-bit FloPoCo square-root core (and of any other 5/5 FloPoCo operator).
- Converts packed IEEE-style binary (1 sign, WE-bit exponent with bias 2^(WE-1)-1, WF-bit fraction) into FloPoCo internal format {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
- 2-stage valid/ready pipeline with sticky exception flags, so operand streams can be throttled before feeding fixed-latency cores.

Parameters:
- ID, 1, instance tag; no functional effect.
- WE, 5, exponent width; only 5 is verified.
- WF, 5, fraction width; only 5 is verified.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word this cycle.
- in_data  in  1+WE+WF (11)  {sign, exp, frac}, IEEE-style.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data; tie to 1 when feeding a fixed-latency core.
- out_data  out  3+WE+WF (13)  {exn, sign, exp, frac}, FloPoCo format.
- flag_clr  in  1  synchronous clear of the sticky flags.
- flags  out  3  sticky flags {flush, inf, nan}.

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset values: out_valid=0, out_data=0, flags=0, both stage-valid bits 0. in_ready is combinational and equals 1 during and after reset.
- Reset mid-operation discards all in-flight words. No partial output may appear after reset is released.
- Handshake: a transfer happens on a cycle where valid&&ready is true.
  - out_data must be held stable while out_valid=1 and out_ready=0.
  - in_ready must not depend on in_valid.
- Pipeline:
  - S1 registers the decode: class, sign, raw exp, raw frac, and leading-one info.
  - S2 registers the packed output.
  - A stage loads when it is empty or when its contents advance in the same cycle (bubble collapsing).
  - in_ready = !s1_v || !s2_v || out_ready.
  - Latency is 2 cycles from accept to out_valid when not stalled. Throughput is 1 word per cycle.
- Classification, with E=exp and F=frac:
  - E=31, F≠0 → exn=11 (NaN); out exp/frac = 0; sign preserved.
  - E=31, F=0 → exn=10 (inf); exp/frac = 0.
  - E=0, F=0 → exn=00 (zero); sign preserved.
  - 1≤E≤30 → exn=01; exp=E and frac=F, passed unchanged because the bias is identical.
  - E=0, F≠0 (subnormal) → handled per the optional feature.
- Flags:
  - Each flag sets when the corresponding word leaves S2 (out_valid && out_ready).
  - Flags hold until flag_clr=1. If clear and set coincide, set wins.
  - flush sets whenever a nonzero subnormal is output as zero.

Optional Feature:
- Macro: FP_IEEE2FLOPOCO_SUBNORM_EN.
- Defined:
  - Subnormals with F[4]=1 (value 1.F[3:0] × 2^-15) are normalized: exn=01, exp=0, frac={F[3:0],1'b0}. flush is not set.
  - Subnormals with F[4]=0 are below FloPoCo range: they become exn=00 with sign preserved, and flush is set.
  - Leading-zero detection sits in S1.
- Undefined: every subnormal flushes to signed zero and sets flush. The leading-zero logic is not built.

Decomposition:
- Package flopoco_pkg holds:
  - localparams WE=5, WF=5, BIAS=15;
  - exception enum exn_t {EXN_ZERO=2'b00, EXN_NORM=2'b01, EXN_INF=2'b10, EXN_NAN=2'b11};
  - packed structs ieee_t {sign, exp, frac} and flopoco_t {exn, sign, exp, frac}.
- One sub-module, fp_pipe_stage: a generic valid/ready register slice, instantiated twice with payload width set by parameter.
- Classification and packing stay inline.

Test Plan:
- Normal passthrough: in_data=11'b0_01111_00000 (1.0), out_ready=1 → two cycles later out_data=13'b01_0_01111_00000, flags=000.
- Specials: stream NaN 11'b0_11111_00001, +inf 11'b0_11111_00000, −0 11'b1_00000_00000 back-to-back.
  - Outputs on consecutive cycles: 13'b11_0_00000_00000, 13'b10_0_00000_00000, 13'b00_1_00000_00000.
  - flags=011.
- Subnormal 11'b0_00000_10100:
  - with the macro → 13'b01_0_00000_01000, flags=000;
  - without → 13'b00_0_00000_00000, flags=100.
  - 11'b0_00000_00011 → zero with flush=1 in both builds.
- Backpressure:
  - Push 3 words with out_ready=0. in_ready drops after the 2nd accept, and out_data is held stable.
  - Raise out_ready: all 3 words emerge in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with both stages full → out_valid=0 immediately (asynchronously), flags=000, nothing emitted after release. flag_clr coinciding with a NaN output leaves nan=1.
